operation_unit_output_serializer: RTL and testbench

- Sits directly downstream of the operation-unit delay line and the AES pipeline.
- Combines the AES output word with the delay-aligned operand word (bitwise XOR, 1024 b), buffers the result, and streams it out as eight 128-bit beats over a valid/ready interface.
- The AES pipe and delay line cannot stall, so this block also issues credits to the upstream issue logic. A word is only launched when a buffer slot is guaranteed at arrival.

---
 rtl/operation_unit_output_serializer.sv | 187 ++++++++++++++++++
 tb/tb_operation_unit_output_serializer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operation_unit_output_serializer.sv
// Output serializer for the operation unit.
// XORs the AES word with the delay-aligned operand word, buffers the result
// in a small circular buffer and streams each 1024-bit word as eight
// 128-bit beats over valid/ready. Because neither the AES pipe nor the
// delay line can stall, the block also hands out issue credits so that a
// word is launched only when a buffer slot is guaranteed at arrival.
module operation_unit_output_serializer #(
    parameter int AES_LATENCY = 29,
    parameter int DEPTH       = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           issue_in,
    output logic                           issue_ok,
    input  logic [1023:0]                  aes_in,
    input  logic [1023:0]                  fifo_in,
    input  logic                           word_valid_in,
    output logic [127:0]                   out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           out_last,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy,
    output logic                           overflow_err,
    output logic                           credit_err
);

    // A single-entry buffer still needs a one-bit pointer so the array index is legal.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(AES_LATENCY + DEPTH + 1);
    // One extra bit so occupancy + inflight can never wrap in the credit compare.
    localparam int SUM_W = INF_W + 1;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [INF_W-1:0] INF_MAX  = '1;
    localparam logic [2:0]       BEAT_LAST = 3'd7;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          beat_q, beat_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]    occ_q, occ_d;
    logic [INF_W-1:0]    infl_q, infl_d;
    logic                ovf_q, ovf_d;
    logic                cerr_q, cerr_d;

    logic [1023:0]       mem_q [DEPTH];

    logic                full;
    logic                handshake;
    logic                pop;
    logic                push_ok;
    logic                drop;
    logic [SUM_W-1:0]    credit_sum;

    // Buffer status and the handshake/pop/push qualifiers shared by all next-state logic.
    always_comb begin
        full       = (occ_q == OCC_FULL);
        handshake  = (state_q == STREAM) && out_ready;
        pop        = handshake && (beat_q == BEAT_LAST);
        // A pop in the same cycle frees the slot, so a word arriving into a full buffer is still taken.
        push_ok    = word_valid_in && (!full || pop);
        drop       = word_valid_in && full && !pop;
        credit_sum = SUM_W'(occ_q) + SUM_W'(infl_q);
    end

    // Stream FSM: leave IDLE once a word is buffered, return when the last word is popped.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                beat_d = 3'd0;
                if (push_ok) begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (handshake) begin
                    beat_d = beat_q + 3'd1;
                end
                if (pop && !push_ok && (occ_q == OCC_W'(1))) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = 3'd0;
            end
        endcase
    end

    // Circular-buffer pointers and occupancy; pointers wrap explicitly so any DEPTH works.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    // In-flight credit tracking plus the two sticky error flags.
    always_comb begin
        infl_d = infl_q;
        ovf_d  = ovf_q;
        cerr_d = cerr_q;
        if (issue_in && !word_valid_in) begin
            if (infl_q != INF_MAX) begin
                infl_d = infl_q + INF_W'(1);
            end
        end else if (!issue_in && word_valid_in) begin
            // An arrival with nothing in flight is a protocol slip; hold at zero rather than wrap.
            if (infl_q != '0) begin
                infl_d = infl_q - INF_W'(1);
            end
        end
        if (drop) begin
            ovf_d = 1'b1;
        end
        if (issue_in && !issue_ok) begin
            cerr_d = 1'b1;
        end
    end

    // State register; reset discards every buffered and in-flight word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= 3'd0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            infl_q   <= '0;
            ovf_q    <= 1'b0;
            cerr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            infl_q   <= infl_d;
            ovf_q    <= ovf_d;
            cerr_q   <= cerr_d;
        end
    end

    // Buffer storage holds the combined word; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= aes_in ^ fifo_in;
        end
    end

    // Output beat selection; data is forced to zero whenever nothing is being streamed.
    always_comb begin
        out_data  = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        if (state_q == STREAM) begin
            out_valid = 1'b1;
            out_data  = mem_q[rd_ptr_q][{beat_q, 7'd0} +: 128];
            out_last  = (beat_q == BEAT_LAST);
        end
    end

    assign issue_ok     = (credit_sum < SUM_W'(DEPTH));
    assign occupancy    = occ_q;
    assign overflow_err = ovf_q;
    assign credit_err   = cerr_q;

endmodule

// File: tb/tb_operation_unit_output_serializer.sv
// Self-checking bench for operation_unit_output_serializer.
// A queue-based model of the buffer, beat position and credit count predicts
// every output; directed scenarios plus a randomized run are compared to it.
module tb_operation_unit_output_serializer;

    localparam int AES_LATENCY = 29;
    localparam int DEPTH       = 2;
    localparam int OCC_W       = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              issue_in = 1'b0;
    logic              issue_ok;
    logic [1023:0]     aes_in = '0;
    logic [1023:0]     fifo_in = '0;
    logic              word_valid_in = 1'b0;
    logic [127:0]      out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              out_last;
    logic [OCC_W-1:0]  occupancy;
    logic              overflow_err;
    logic              credit_err;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [1023:0] mq[$];
    int            mbeat = 0;
    int            minfl = 0;
    bit            movf  = 1'b0;
    bit            mcerr = 1'b0;

    operation_unit_output_serializer #(
        .AES_LATENCY(AES_LATENCY),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .issue_in(issue_in),
        .issue_ok(issue_ok),
        .aes_in(aes_in),
        .fifo_in(fifo_in),
        .word_valid_in(word_valid_in),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .occupancy(occupancy),
        .overflow_err(overflow_err),
        .credit_err(credit_err)
    );

    // Free-running clock
    always #5 clk = ~clk;

    function automatic logic [1023:0] rand_word();
        logic [1023:0] w;
        for (int i = 0; i < 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    function automatic logic [127:0] beat_of(input logic [1023:0] w, input int k);
        return w[k*128 +: 128];
    endfunction

    function automatic logic exp_valid();
        return mq.size() > 0;
    endfunction

    function automatic logic [127:0] exp_data();
        logic [1023:0] w;
        if (mq.size() == 0) return '0;
        w = mq[0];
        return w[mbeat*128 +: 128];
    endfunction

    function automatic logic exp_last();
        return (mq.size() > 0) && (mbeat == 7);
    endfunction

    function automatic logic exp_ok();
        return (mq.size() + minfl) < DEPTH;
    endfunction

    // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit after it.
    task automatic step(input logic iss, input logic wv, input logic [1023:0] a,
                        input logic [1023:0] f, input logic rdy);
        int sz;
        bit valid;
        bit pop;
        issue_in      = iss;
        word_valid_in = wv;
        aes_in        = a;
        fifo_in       = f;
        out_ready     = rdy;
        @(posedge clk);
        sz    = mq.size();
        valid = (sz > 0);
        pop   = valid && rdy && (mbeat == 7);
        if (iss && !((sz + minfl) < DEPTH)) mcerr = 1'b1;
        if (valid && rdy) begin
            if (mbeat == 7) begin
                mbeat = 0;
                void'(mq.pop_front());
            end else begin
                mbeat++;
            end
        end
        if (wv) begin
            if ((sz - (pop ? 1 : 0)) < DEPTH) mq.push_back(a ^ f);
            else movf = 1'b1;
        end
        if (iss && !wv) minfl++;
        else if (!iss && wv && minfl > 0) minfl--;
        #1;
    endtask

    task automatic do_reset();
        #1;
        rst_n         = 1'b0;
        issue_in      = 1'b0;
        word_valid_in = 1'b0;
        out_ready     = 1'b0;
        aes_in        = '0;
        fifo_in       = '0;
        mq.delete();
        mbeat = 0;
        minfl = 0;
        movf  = 1'b0;
        mcerr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_valid); end
        total++; if (occupancy !== '0) begin bad++; $display("[TB] FAIL reset_occ got=%0d want=0", occupancy); end
        total++; if (issue_ok !== 1'b1) begin bad++; $display("[TB] FAIL reset_issue_ok got=%b want=1", issue_ok); end
        do_reset();
        total++; if (out_data !== '0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0", out_data); end
        total++; if (out_last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last got=%b want=0", out_last); end
        total++; if (overflow_err !== 1'b0 || credit_err !== 1'b0) begin bad++; $display("[TB] FAIL reset_errs got=%b%b want=00", overflow_err, credit_err); end
    endtask

    task automatic test_single_word();
        logic [127:0] want;
        want = {16{8'hAA}};
        do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < AES_LATENCY - 1; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        total++; if (issue_ok !== 1'b1) begin bad++; $display("[TB] FAIL single_credit got=%b want=1", issue_ok); end
        step(1'b0, 1'b1, {128{8'hA5}}, {128{8'h0F}}, 1'b1);
        total++; if (occupancy !== OCC_W'(1)) begin bad++; $display("[TB] FAIL single_occ got=%0d want=1", occupancy); end
        for (int k = 0; k < 8; k++) begin
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid beat=%0d got=%b want=1", k, out_valid); end
            total++; if (out_data !== want) begin bad++; $display("[TB] FAIL single_data beat=%0d got=%h want=%h", k, out_data, want); end
            total++; if (out_last !== (k == 7)) begin bad++; $display("[TB] FAIL single_last beat=%0d got=%b want=%b", k, out_last, (k == 7)); end
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_after_valid got=%b want=0", out_valid); end
        total++; if (occupancy !== '0) begin bad++; $display("[TB] FAIL single_after_occ got=%0d want=0", occupancy); end
        total++; if (out_last !== 1'b0) begin bad++; $display("[TB] FAIL single_after_last got=%b want=0", out_last); end
    endtask

    task automatic test_backpressure();
        logic [1023:0] pat;
        logic [1023:0] r;
        logic [127:0]  want;
        logic          rdy;
        int            got;
        int            cyc;
        for (int k = 0; k < 8; k++) pat[k*128 +: 128] = {16{8'(k)}};
        r = rand_word();
        do_reset();
        step(1'b0, 1'b1, pat ^ r, r, 1'b0);
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 64) begin
            rdy  = ((cyc % 4) == 0) || ((cyc % 4) == 3);
            want = {16{8'(got)}};
            total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL bp_valid cyc=%0d got=%b want=1", cyc, out_valid); end
            total++; if (out_data !== want) begin bad++; $display("[TB] FAIL bp_data cyc=%0d got=%h want=%h", cyc, out_data, want); end
            total++; if (out_last !== (got == 7)) begin bad++; $display("[TB] FAIL bp_last cyc=%0d got=%b want=%b", cyc, out_last, (got == 7)); end
            if (rdy) got++;
            step(1'b0, 1'b0, '0, '0, rdy);
            cyc++;
        end
        total++; if (got != 8) begin bad++; $display("[TB] FAIL bp_count got=%0d want=8", got); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_after_valid got=%b want=0", out_valid); end
    endtask

    task automatic test_credit_limit();
        logic [1023:0] w1;
        logic [1023:0] w2;
        w1 = rand_word();
        w2 = rand_word();
        do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0);
        total++; if (issue_ok !== 1'b1) begin bad++; $display("[TB] FAIL credit_first got=%b want=1", issue_ok); end
        step(1'b1, 1'b0, '0, '0, 1'b0);
        total++; if (issue_ok !== 1'b0) begin bad++; $display("[TB] FAIL credit_second got=%b want=0", issue_ok); end
        for (int i = 0; i < AES_LATENCY - 2; i++) step(1'b0, 1'b0, '0, '0, 1'b0);
        step(1'b0, 1'b1, w1, '0, 1'b0);
        step(1'b0, 1'b1, w2, '0, 1'b0);
        total++; if (occupancy !== OCC_W'(2)) begin bad++; $display("[TB] FAIL credit_occ got=%0d want=2", occupancy); end
        total++; if (issue_ok !== 1'b0) begin bad++; $display("[TB] FAIL credit_full got=%b want=0", issue_ok); end
        for (int i = 0; i < 8; i++) begin
            total++; if (out_data !== beat_of(w1, i)) begin bad++; $display("[TB] FAIL credit_data beat=%0d got=%h want=%h", i, out_data, beat_of(w1, i)); end
            total++; if (issue_ok !== 1'b0) begin bad++; $display("[TB] FAIL credit_drain beat=%0d got=%b want=0", i, issue_ok); end
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
        total++; if (occupancy !== OCC_W'(1)) begin bad++; $display("[TB] FAIL credit_occ_after got=%0d want=1", occupancy); end
        total++; if (issue_ok !== 1'b1) begin bad++; $display("[TB] FAIL credit_return got=%b want=1", issue_ok); end
        total++; if (out_data !== beat_of(w2, 0)) begin bad++; $display("[TB] FAIL credit_next got=%h want=%h", out_data, beat_of(w2, 0)); end
    endtask

    task automatic test_full_push_pop();
        logic [1023:0] w1;
        logic [1023:0] w2;
        logic [1023:0] w3;
        logic [1023:0] w4;
        int            n;
        w1 = rand_word();
        w2 = rand_word();
        w3 = rand_word();
        w4 = rand_word();
        do_reset();
        step(1'b0, 1'b1, w1, '0, 1'b0);
        step(1'b0, 1'b1, w2, '0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        total++; if (out_last !== 1'b1) begin bad++; $display("[TB] FAIL full_last got=%b want=1", out_last); end
        step(1'b0, 1'b1, w3, '0, 1'b1);
        total++; if (occupancy !== OCC_W'(2)) begin bad++; $display("[TB] FAIL full_pp_occ got=%0d want=2", occupancy); end
        total++; if (overflow_err !== 1'b0) begin bad++; $display("[TB] FAIL full_pp_ovf got=%b want=0", overflow_err); end
        total++; if (out_data !== beat_of(w2, 0)) begin bad++; $display("[TB] FAIL full_pp_data got=%h want=%h", out_data, beat_of(w2, 0)); end
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b0, 1'b1, w4, '0, 1'b1);
        total++; if (overflow_err !== 1'b1) begin bad++; $display("[TB] FAIL full_drop_ovf got=%b want=1", overflow_err); end
        total++; if (occupancy !== OCC_W'(2)) begin bad++; $display("[TB] FAIL full_drop_occ got=%0d want=2", occupancy); end
        total++; if (out_data !== beat_of(w2, 7)) begin bad++; $display("[TB] FAIL full_drop_data got=%h want=%h", out_data, beat_of(w2, 7)); end
        n = 0;
        while (exp_valid() && n < 40) begin
            total++; if (out_valid !== 1'b1 || out_data !== exp_data()) begin bad++; $display("[TB] FAIL full_drain n=%0d got=%b/%h want=1/%h", n, out_valid, out_data, exp_data()); end
            step(1'b0, 1'b0, '0, '0, 1'b1);
            n++;
        end
        total++; if (n != 9) begin bad++; $display("[TB] FAIL full_drain_len got=%0d want=9", n); end
        total++; if (out_valid !== 1'b0 || overflow_err !== 1'b1) begin bad++; $display("[TB] FAIL full_end got=%b%b want=01", out_valid, overflow_err); end
    endtask

    task automatic test_back_to_back();
        logic [1023:0] w1;
        logic [1023:0] w2;
        w1 = rand_word();
        w2 = rand_word();
        do_reset();
        step(1'b0, 1'b1, w1, '0, 1'b1);
        for (int k = 0; k < 7; k++) begin
            total++; if (out_valid !== 1'b1 || out_data !== beat_of(w1, k)) begin bad++; $display("[TB] FAIL b2b_first beat=%0d got=%b/%h want=1/%h", k, out_valid, out_data, beat_of(w1, k)); end
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
        total++; if (out_last !== 1'b1 || occupancy !== OCC_W'(1)) begin bad++; $display("[TB] FAIL b2b_last got=%b/%0d want=1/1", out_last, occupancy); end
        step(1'b0, 1'b1, w2, '0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            total++; if (out_valid !== 1'b1 || out_data !== beat_of(w2, k)) begin bad++; $display("[TB] FAIL b2b_second beat=%0d got=%b/%h want=1/%h", k, out_valid, out_data, beat_of(w2, k)); end
            total++; if (out_last !== (k == 7)) begin bad++; $display("[TB] FAIL b2b_second_last beat=%0d got=%b want=%b", k, out_last, (k == 7)); end
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
        total++; if (out_valid !== 1'b0 || occupancy !== '0) begin bad++; $display("[TB] FAIL b2b_end got=%b/%0d want=0/0", out_valid, occupancy); end
    endtask

    task automatic test_credit_err();
        do_reset();
        step(1'b1, 1'b0, '0, '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        total++; if (credit_err !== 1'b0 || issue_ok !== 1'b0) begin bad++; $display("[TB] FAIL cerr_pre got=%b/%b want=0/0", credit_err, issue_ok); end
        step(1'b1, 1'b0, '0, '0, 1'b0);
        total++; if (credit_err !== 1'b1) begin bad++; $display("[TB] FAIL cerr_set got=%b want=1", credit_err); end
        step(1'b1, 1'b1, rand_word(), '0, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 8; i++) begin
                total++; if (issue_ok !== exp_ok()) begin bad++; $display("[TB] FAIL cerr_ok r=%0d i=%0d got=%b want=%b", r, i, issue_ok, exp_ok()); end
                step(1'b0, 1'b0, '0, '0, 1'b1);
            end
            total++; if (issue_ok !== (r == 2)) begin bad++; $display("[TB] FAIL cerr_infl r=%0d got=%b want=%b", r, issue_ok, (r == 2)); end
            total++; if (credit_err !== 1'b1) begin bad++; $display("[TB] FAIL cerr_sticky r=%0d got=%b want=1", r, credit_err); end
            if (r < 2) step(1'b0, 1'b1, rand_word(), '0, 1'b1);
        end
        step(1'b0, 1'b1, rand_word(), '0, 1'b1);
        step(1'b0, 1'b1, rand_word(), '0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        total++; if (issue_ok !== 1'b1) begin bad++; $display("[TB] FAIL cerr_saturate got=%b want=1", issue_ok); end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        step(1'b0, 1'b1, rand_word(), '0, 1'b0);
        step(1'b0, 1'b1, rand_word(), '0, 1'b0);
        step(1'b1, 1'b0, '0, '0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0, '0, 1'b1);
        total++; if (out_data !== exp_data() || mbeat != 3) begin bad++; $display("[TB] FAIL mid_beat3 got=%h want=%h", out_data, exp_data()); end
        #2;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        issue_in  = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%b want=0", out_valid); end
        total++; if (occupancy !== '0) begin bad++; $display("[TB] FAIL mid_occ got=%0d want=0", occupancy); end
        total++; if (out_data !== '0 || out_last !== 1'b0) begin bad++; $display("[TB] FAIL mid_data got=%h/%b want=0/0", out_data, out_last); end
        mq.delete();
        mbeat = 0;
        minfl = 0;
        movf  = 1'b0;
        mcerr = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (issue_ok !== 1'b1) begin bad++; $display("[TB] FAIL mid_issue_ok got=%b want=1", issue_ok); end
        for (int i = 0; i < 10; i++) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_stale i=%0d got=%b want=0", i, out_valid); end
            step(1'b0, 1'b0, '0, '0, 1'b1);
        end
        step(1'b1, 1'b0, '0, '0, 1'b1);
        total++; if (issue_ok !== 1'b1) begin bad++; $display("[TB] FAIL mid_infl_one got=%b want=1", issue_ok); end
        step(1'b1, 1'b0, '0, '0, 1'b1);
        total++; if (issue_ok !== 1'b0) begin bad++; $display("[TB] FAIL mid_infl_two got=%b want=0", issue_ok); end
    endtask

    task automatic test_random();
        logic iss;
        logic wv;
        logic rdy;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (exp_ok()) iss = ($urandom_range(0, 1) == 1);
            else          iss = ($urandom_range(0, 15) == 0) && (minfl < 20);
            wv  = ((minfl > 0) && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 39) == 0);
            rdy = ($urandom_range(0, 3) != 0);
            step(iss, wv, rand_word(), rand_word(), rdy);
            total++;
            if (out_valid !== exp_valid() || out_data !== exp_data() || out_last !== exp_last() ||
                occupancy !== OCC_W'(mq.size()) || issue_ok !== exp_ok() ||
                overflow_err !== movf || credit_err !== mcerr) begin
                bad++;
                $display("[TB] FAIL rand c=%0d got v%b l%b o%0d k%b e%b%b d=%h want v%b l%b o%0d k%b e%b%b d=%h",
                         c, out_valid, out_last, occupancy, issue_ok, overflow_err, credit_err, out_data,
                         exp_valid(), exp_last(), mq.size(), exp_ok(), movf, mcerr, exp_data());
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_credit_limit();
        test_full_push_pop();
        test_back_to_back();
        test_credit_err();
        test_reset_midstream();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
